// File: rtl/conv_back_seq_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the CONV_BACK sequencer slice: the sequencer state
// encoding and the default job geometry (operand width, rows, columns,
// passes) plus the derived number of operand beats streamed per job.
// ---------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_STREAM = 3'd2,
        ST_TAIL   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ROWS   = 8;
    localparam int DEF_COLS   = 16;
    localparam int DEF_PASSES = 2;

    // Operand pairs streamed into CONV_BACK for one complete job.
    localparam int DEF_BEATS  = DEF_ROWS * DEF_COLS * DEF_PASSES;

endpackage

// File: rtl/conv_back_seq_if.sv
// ---------------------------------------------------------------------------
// conv_back_seq_if
// Bundles every data-path connection of the sequencer:
//   - image / weight synchronous-read memory ports (address out, data in)
//   - CONV_BACK engine drive (en, in, weight) and its result/valid return
//   - result memory write port (we, addr, wdata)
// Modport master is the sequencer side, slave is the memory/engine side.
// ---------------------------------------------------------------------------
interface conv_back_seq_if #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 7,
    parameter int RES_ADDR_W = 4
);

    logic [ADDR_W-1:0]     img_addr;
    logic [DATA_W-1:0]     img_rdata;
    logic [ADDR_W-1:0]     wgt_addr;
    logic [DATA_W-1:0]     wgt_rdata;
    logic                  conv_en;
    logic [DATA_W-1:0]     conv_in;
    logic [DATA_W-1:0]     conv_weight;
    logic [DATA_W-1:0]     conv_result;
    logic                  conv_sig;
    logic                  res_we;
    logic [RES_ADDR_W-1:0] res_addr;
    logic [DATA_W-1:0]     res_wdata;

    modport master (
        output img_addr, wgt_addr, conv_en, conv_in, conv_weight,
               res_we, res_addr, res_wdata,
        input  img_rdata, wgt_rdata, conv_result, conv_sig
    );

    modport slave (
        input  img_addr, wgt_addr, conv_en, conv_in, conv_weight,
               res_we, res_addr, res_wdata,
        output img_rdata, wgt_rdata, conv_result, conv_sig
    );

endinterface

// File: rtl/conv_back_seq_addr_gen.sv
// ---------------------------------------------------------------------------
// conv_addr_gen
// Nested column/row/pass counters for the operand stream. The address is
// kept as its own counter (row*COLS + col) so no multiplier is needed; it
// wraps to 0 at every pass boundary.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       restart at beat 0 (takes priority over step)
//   step        advance to the next beat
//   addr        operand memory address of the current beat
//   odd_pass    current beat belongs to an odd pass
//   last_beat   current beat is the final beat of the job
// ---------------------------------------------------------------------------
module conv_addr_gen #(
    parameter int ROWS   = 8,
    parameter int COLS   = 16,
    parameter int PASSES = 2,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              odd_pass,
    output logic              last_beat
);

    localparam int COL_W  = (COLS   > 1) ? $clog2(COLS)   : 1;
    localparam int ROW_W  = (ROWS   > 1) ? $clog2(ROWS)   : 1;
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

    logic [COL_W-1:0]  col_q,  col_d;
    logic [ROW_W-1:0]  row_q,  row_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic col_last, row_last, pass_last;

    assign col_last  = (col_q  == COL_W'(COLS - 1));
    assign row_last  = (row_q  == ROW_W'(ROWS - 1));
    assign pass_last = (pass_q == PASS_W'(PASSES - 1));

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        pass_d = pass_q;
        addr_d = addr_q;
        if (clear) begin
            col_d  = '0;
            row_d  = '0;
            pass_d = '0;
            addr_d = '0;
        end else if (step) begin
            if (!col_last) begin
                col_d  = col_q + 1'b1;
                addr_d = addr_q + 1'b1;
            end else begin
                col_d = '0;
                if (!row_last) begin
                    row_d  = row_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end else begin
                    // End of a pass: address restarts, pass parity flips.
                    row_d  = '0;
                    addr_d = '0;
                    pass_d = pass_last ? '0 : pass_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            pass_q <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            pass_q <= pass_d;
            addr_q <= addr_d;
        end
    end

    assign addr      = addr_q;
    assign odd_pass  = pass_q[0];
    assign last_beat = col_last && row_last && pass_last;

endmodule

// File: rtl/conv_back_seq.sv
// ---------------------------------------------------------------------------
// conv_back_seq
// Sequencer for the CONV_BACK convolution engine. Streams image/weight
// operand pairs from two synchronous-read memories (operands swapped on odd
// passes), keeps conv_en high for a short tail, then drains results flagged
// by conv_sig into the result write port and pulses done.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       one-cycle job start, accepted only while idle
//   busy        high from accepted start through the done cycle
//   done        one-cycle end-of-job pulse
//   err         sticky drain-timeout flag, cleared by the next start
//   bus         memory, engine and result ports (master modport)
// ---------------------------------------------------------------------------
module conv_back_seq
    import conv_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ROWS          = DEF_ROWS,
    parameter int COLS          = DEF_COLS,
    parameter int PASSES        = DEF_PASSES,
    parameter int ADDR_W        = 7,
    parameter int TAIL_CYCLES   = 2,
    parameter int EXP_RESULTS   = 16,
    parameter int RES_ADDR_W    = 4,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    conv_back_seq_if.master bus
);

    localparam int TAIL_W  = $clog2(TAIL_CYCLES + 1);
    localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT);
    localparam int RES_W   = $clog2(EXP_RESULTS + 1);

    state_t                state_q,     state_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;
    logic                  err_q,       err_d;
    logic                  conv_en_q,   conv_en_d;
    logic [DATA_W-1:0]     conv_in_q,   conv_in_d;
    logic [DATA_W-1:0]     conv_wgt_q,  conv_wgt_d;
    logic                  res_we_q,    res_we_d;
    logic [RES_ADDR_W-1:0] res_addr_q,  res_addr_d;
    logic [DATA_W-1:0]     res_wdata_q, res_wdata_d;
    logic [RES_W-1:0]      res_cnt_q,   res_cnt_d;
    logic [TAIL_W-1:0]     tail_cnt_q,  tail_cnt_d;
    logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic                  pipe_odd_q,  pipe_odd_d;
    logic                  pipe_last_q, pipe_last_d;

    logic              gen_clear, gen_step;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_odd, gen_last;

    conv_addr_gen #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .PASSES (PASSES),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (gen_clear),
        .step      (gen_step),
        .addr      (gen_addr),
        .odd_pass  (gen_odd),
        .last_beat (gen_last)
    );

    // Read data returns one cycle after its address, so the pass parity and
    // last-beat flag of the issued address ride along in pipe_* to line up
    // with the data when it is registered into conv_in/conv_weight.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        conv_en_d   = conv_en_q;
        conv_in_d   = conv_in_q;
        conv_wgt_d  = conv_wgt_q;
        res_we_d    = 1'b0;
        res_addr_d  = res_addr_q;
        res_wdata_d = res_wdata_q;
        res_cnt_d   = res_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        drain_cnt_d = drain_cnt_q;
        pipe_odd_d  = pipe_odd_q;
        pipe_last_d = pipe_last_q;
        gen_clear   = 1'b0;
        gen_step    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_PRIME;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                    res_cnt_d = '0;
                    gen_clear = 1'b1;
                end
            end
            ST_PRIME: begin
                gen_step    = 1'b1;
                pipe_odd_d  = gen_odd;
                pipe_last_d = gen_last;
                state_d     = ST_STREAM;
            end
            ST_STREAM: begin
                conv_en_d  = 1'b1;
                conv_in_d  = pipe_odd_q ? bus.wgt_rdata : bus.img_rdata;
                conv_wgt_d = pipe_odd_q ? bus.img_rdata : bus.wgt_rdata;
                if (pipe_last_q) begin
                    state_d    = ST_TAIL;
                    tail_cnt_d = '0;
                end else begin
                    gen_step    = 1'b1;
                    pipe_odd_d  = gen_odd;
                    pipe_last_d = gen_last;
                end
            end
            ST_TAIL: begin
                if (tail_cnt_q == TAIL_W'(TAIL_CYCLES)) begin
                    state_d     = ST_DRAIN;
                    conv_en_d   = 1'b0;
                    drain_cnt_d = '0;
                end else begin
                    tail_cnt_d = tail_cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (res_cnt_q == RES_W'(EXP_RESULTS)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (drain_cnt_q == DRAIN_W'(DRAIN_TIMEOUT - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Results are collected in every active state; once the expected
        // count is reached further pulses are dropped so res_addr never wraps.
        if (state_q != ST_IDLE && bus.conv_sig &&
            res_cnt_q < RES_W'(EXP_RESULTS)) begin
            res_we_d    = 1'b1;
            res_addr_d  = RES_ADDR_W'(res_cnt_q);
            res_wdata_d = bus.conv_result;
            res_cnt_d   = res_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            conv_en_q   <= 1'b0;
            conv_in_q   <= '0;
            conv_wgt_q  <= '0;
            res_we_q    <= 1'b0;
            res_addr_q  <= '0;
            res_wdata_q <= '0;
            res_cnt_q   <= '0;
            tail_cnt_q  <= '0;
            drain_cnt_q <= '0;
            pipe_odd_q  <= 1'b0;
            pipe_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            conv_en_q   <= conv_en_d;
            conv_in_q   <= conv_in_d;
            conv_wgt_q  <= conv_wgt_d;
            res_we_q    <= res_we_d;
            res_addr_q  <= res_addr_d;
            res_wdata_q <= res_wdata_d;
            res_cnt_q   <= res_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            pipe_odd_q  <= pipe_odd_d;
            pipe_last_q <= pipe_last_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign bus.img_addr    = gen_addr;
    assign bus.wgt_addr    = gen_addr;
    assign bus.conv_en     = conv_en_q;
    assign bus.conv_in     = conv_in_q;
    assign bus.conv_weight = conv_wgt_q;
    assign bus.res_we      = res_we_q;
    assign bus.res_addr    = res_addr_q;
    assign bus.res_wdata   = res_wdata_q;

endmodule

// File: tb/tb_conv_back_seq.sv
// ---------------------------------------------------------------------------
// tb_conv_back_seq
// Directed bench for conv_back_seq with default parameters. Memories hold
// img[a] = a+1 and wgt[a] = 23-a; a stub engine pulses conv_sig after
// conv_en falls, with conv_result = 16'hA000 + pulse index. A monitor keeps
// job-relative cycle numbers (cycle 0 = start-accept edge) and statistics.
// ---------------------------------------------------------------------------
module tb_conv_back_seq;
    import conv_pkg::*;

    localparam int PASS_BEATS = DEF_ROWS * DEF_COLS;

    logic clk;
    logic rst_n;
    logic start;
    logic busy;
    logic done;
    logic err;

    conv_back_seq_if #(.DATA_W(16), .ADDR_W(7), .RES_ADDR_W(4)) bus ();

    conv_back_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read operand memories.
    always @(posedge clk) begin
        bus.img_rdata <= 16'(bus.img_addr) + 16'd1;
        bus.wgt_rdata <= 16'd23 - 16'(bus.wgt_addr);
    end

    int n_checks = 0;
    int n_fail   = 0;

    int   cyc = 0;
    logic new_job = 1'b0;
    int   en_cycles, first_en_cyc, last_en_cyc, en_gap, data_err;
    int   wr_cnt, addr_err, max_addr, done_cnt, done_cyc, busy_last_cyc;
    logic err_at_done;
    logic [15:0] beat0_in, beat0_wt, beat128_in, beat128_wt;

    function automatic logic [15:0] exp_in(input int k);
        int a;
        a = k % PASS_BEATS;
        return ((k / PASS_BEATS) % 2 == 1) ? 16'(23 - a) : 16'(a + 1);
    endfunction

    function automatic logic [15:0] exp_wt(input int k);
        int a;
        a = k % PASS_BEATS;
        return ((k / PASS_BEATS) % 2 == 1) ? 16'(a + 1) : 16'(23 - a);
    endfunction

    always @(posedge clk) begin
        new_job = start && !busy && rst_n;
        if (new_job) cyc = 0;
        else         cyc = cyc + 1;
    end

    always @(negedge clk) begin
        int k;
        if (new_job) begin
            en_cycles = 0; first_en_cyc = -1; last_en_cyc = -1; en_gap = 0;
            data_err = 0; wr_cnt = 0; addr_err = 0; max_addr = -1;
            done_cnt = 0; done_cyc = -1; busy_last_cyc = -1; err_at_done = 1'bx;
            beat0_in = '0; beat0_wt = '0; beat128_in = '0; beat128_wt = '0;
        end
        if (bus.conv_en) begin
            en_cycles++;
            if (first_en_cyc < 0) first_en_cyc = cyc;
            else if (last_en_cyc != cyc - 1) en_gap++;
            last_en_cyc = cyc;
            k = cyc - 2;
            if (k > DEF_BEATS - 1) k = DEF_BEATS - 1;
            if (k < 0 || bus.conv_in !== exp_in(k) || bus.conv_weight !== exp_wt(k))
                data_err++;
            if (cyc == 2)   begin beat0_in   = bus.conv_in; beat0_wt   = bus.conv_weight; end
            if (cyc == 130) begin beat128_in = bus.conv_in; beat128_wt = bus.conv_weight; end
        end
        if (bus.res_we) begin
            if (bus.res_addr !== 4'(wr_cnt) || bus.res_wdata !== 16'(32'hA000 + wr_cnt))
                addr_err++;
            if (int'(bus.res_addr) > max_addr) max_addr = int'(bus.res_addr);
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc    = cyc;
            err_at_done = err;
        end
        if (busy) busy_last_cyc = cyc;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One full job: start pulse, optional stray starts at cycles 50/100,
    // wait for conv_en to fall, pulse conv_sig n_pulses times, wait for done.
    task automatic applyStimulus(input int n_pulses, input bit mid_starts);
        int   guard;
        logic seen_en;
        logic timed_out;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        guard = 0; seen_en = 1'b0; timed_out = 1'b0;
        while (!(seen_en && !bus.conv_en) && !timed_out) begin
            @(negedge clk);
            start = mid_starts && (cyc == 50 || cyc == 100);
            if (bus.conv_en) seen_en = 1'b1;
            guard++;
            if (guard > 1000) timed_out = 1'b1;
        end
        start = 1'b0;
        checkOutput("wait_stream_end", 32'(timed_out), 32'd0);
        for (int j = 0; j < n_pulses; j++) begin
            bus.conv_sig    = 1'b1;
            bus.conv_result = 16'(32'hA000 + j);
            @(negedge clk);
        end
        bus.conv_sig = 1'b0;
        guard = 0; timed_out = 1'b0;
        while (done_cnt == 0 && !timed_out) begin
            @(negedge clk);
            guard++;
            if (guard > 1500) timed_out = 1'b1;
        end
        checkOutput("wait_done", 32'(timed_out), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; start = 1'b0;
        bus.conv_sig = 1'b0; bus.conv_result = '0;
        #12;
        checkOutput("reset_busy",    32'(busy),         32'd0);
        checkOutput("reset_conv_en", 32'(bus.conv_en),  32'd0);
        checkOutput("reset_addr",    32'(bus.img_addr), 32'd0);
        checkOutput("reset_err",     32'(err),          32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] basic job");
        applyStimulus(16, 1'b0);
        checkOutput("first_en_cyc",  32'(first_en_cyc),  32'd2);
        checkOutput("last_en_cyc",   32'(last_en_cyc),   32'd259);
        checkOutput("en_gap",        32'(en_gap),        32'd0);
        checkOutput("en_cycles",     32'(en_cycles),     32'd258);
        checkOutput("beat0_in",      32'(beat0_in),      32'd1);
        checkOutput("beat0_wt",      32'(beat0_wt),      32'd23);
        checkOutput("beat128_in",    32'(beat128_in),    32'd23);
        checkOutput("beat128_wt",    32'(beat128_wt),    32'd1);
        checkOutput("beat_data",     32'(data_err),      32'd0);
        checkOutput("writes",        32'(wr_cnt),        32'd16);
        checkOutput("write_seq",     32'(addr_err),      32'd0);
        checkOutput("max_res_addr",  32'(max_addr),      32'd15);
        checkOutput("done_count",    32'(done_cnt),      32'd1);
        checkOutput("done_cyc",      32'(done_cyc),      32'd277);
        checkOutput("busy_last_cyc", 32'(busy_last_cyc), 32'd277);
        checkOutput("err_at_done",   32'(err_at_done),   32'd0);

        $display("[TB] drain timeout");
        applyStimulus(10, 1'b0);
        checkOutput("to_writes",      32'(wr_cnt),      32'd10);
        checkOutput("to_done_cyc",    32'(done_cyc),    32'd1284);
        checkOutput("to_err_at_done", 32'(err_at_done), 32'd1);
        checkOutput("to_err_sticky",  32'(err),         32'd1);

        $display("[TB] excess results");
        fork
            applyStimulus(20, 1'b0);
            begin
                repeat (3) @(negedge clk);
                checkOutput("err_cleared", 32'(err), 32'd0);
            end
        join
        checkOutput("ex_writes",     32'(wr_cnt),   32'd16);
        checkOutput("ex_write_seq",  32'(addr_err), 32'd0);
        checkOutput("ex_max_addr",   32'(max_addr), 32'd15);
        checkOutput("ex_done_count", 32'(done_cnt), 32'd1);

        $display("[TB] start while busy");
        applyStimulus(16, 1'b1);
        checkOutput("mid_en_cycles",  32'(en_cycles), 32'd258);
        checkOutput("mid_beat_data",  32'(data_err),  32'd0);
        checkOutput("mid_done_count", 32'(done_cnt),  32'd1);

        $display("[TB] reset mid-job");
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        guard = 0;
        while (cyc != 80 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("wait_cyc80", 32'(guard < 200), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy",    32'(busy),            32'd0);
        checkOutput("rst_conv_en", 32'(bus.conv_en),     32'd0);
        checkOutput("rst_conv_in", 32'(bus.conv_in),     32'd0);
        checkOutput("rst_conv_wt", 32'(bus.conv_weight), 32'd0);
        checkOutput("rst_addr",    32'(bus.img_addr),    32'd0);
        @(negedge clk); rst_n = 1'b1;
        applyStimulus(16, 1'b0);
        checkOutput("re_beat0_in",  32'(beat0_in),  32'd1);
        checkOutput("re_en_cycles", 32'(en_cycles), 32'd258);
        checkOutput("re_beat_data", 32'(data_err),  32'd0);
        checkOutput("re_writes",    32'(wr_cnt),    32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
